// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame-checker state encoding
// and parity type constants.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_err_counter.sv
// Saturating error counter. A clear takes priority over an increment, and the
// count holds at all-ones once it gets there.
module sat_err_counter #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] cnt
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_check.sv
// UART RX frame checker: assembles LSB-first data bits, checks parity and one
// or two stop bits. UART_FRAME_ERR_CNT_EN adds saturating error counters.
//
//   state  | meaning
//   IDLE   | waiting for frame_start
//   DATA   | shifting in DATA_WIDTH data bits
//   PARITY | sampling the parity bit (only if par_en was latched)
//   STOP   | sampling one or two stop bits, completion on the last one
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
`ifdef UART_FRAME_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W  = 8
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  sampled_bit,
    input  logic                  frame_start,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  two_stop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
`ifdef UART_FRAME_ERR_CNT_EN
    ,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  stp_err_cnt
`endif
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  run_par_q, run_par_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_seen_q, stop_seen_d;
    logic                  par_err_d, stp_err_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  data_valid_d, frame_done_d;
    logic [PRESCALE_W-1:0] prescale_m1;
    logic                  strobe;

    // Wraps modulo 2^PRESCALE_W, matching the edge counter width.
    assign prescale_m1 = PRESCALE - 1'b1;
    assign strobe      = (edge_cnt == prescale_m1);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            run_par_q   <= 1'b0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_par_q   <= run_par_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            two_stop_q  <= two_stop_d;
            stop_seen_q <= stop_seen_d;
            par_err     <= par_err_d;
            stp_err     <= stp_err_d;
            data_out    <= data_d;
            data_valid  <= data_valid_d;
            frame_done  <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_par_d    = run_par_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        two_stop_d   = two_stop_q;
        stop_seen_d  = stop_seen_q;
        par_err_d    = par_err;
        stp_err_d    = stp_err;
        data_d       = data_out;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;

        // A start in any state restarts the frame, abandoning any frame in flight.
        if (frame_start) begin
            par_en_d    = par_en;
            par_typ_d   = par_typ;
            two_stop_d  = two_stop;
            par_err_d   = 1'b0;
            stp_err_d   = 1'b0;
            idx_d       = '0;
            run_par_d   = 1'b0;
            stop_seen_d = 1'b0;
            state_d     = DATA;
        end else begin
            case (state_q)
                IDLE: begin
                end
                DATA: begin
                    if (strobe) begin
                        shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        run_par_d = run_par_q ^ sampled_bit;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (strobe) begin
                        par_err_d = sampled_bit ^ run_par_q ^ (par_typ_q == PAR_ODD);
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (strobe) begin
                        stp_err_d = stp_err | ~sampled_bit;
                        if (two_stop_q && !stop_seen_q) begin
                            stop_seen_d = 1'b1;
                        end else begin
                            data_d       = shift_q;
                            frame_done_d = 1'b1;
                            data_valid_d = !par_err && !stp_err_d;
                            state_d      = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef UART_FRAME_ERR_CNT_EN
    sat_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_par_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (frame_done & par_err),
        .clr (err_clr),
        .cnt (par_err_cnt)
    );

    sat_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_stp_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (frame_done & stp_err),
        .clr (err_clr),
        .cnt (stp_err_cnt)
    );
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// Scoreboard bench for uart_frame_check: directed frames push expected results,
// a negedge monitor compares them whenever frame_done is presented.
module tb_uart_frame_check;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [PW-1:0] PRESCALE = 6'd8;
    logic [PW-1:0] edge_cnt = '0;
    logic          sampled_bit = 1'b1;
    logic          frame_start = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          two_stop = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid, frame_done, par_err, stp_err, busy;
`ifdef UART_FRAME_ERR_CNT_EN
    logic          err_clr = 1'b0;
    logic [1:0]    par_err_cnt, stp_err_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          v;
        logic          pe;
        logic          se;
    } exp_t;

    exp_t exp_q[$];

    uart_frame_check #(
        .DATA_WIDTH(DW),
        .PRESCALE_W(PW)
`ifdef UART_FRAME_ERR_CNT_EN
        ,
        .ERR_CNT_W (2)
`endif
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PRESCALE   (PRESCALE),
        .edge_cnt   (edge_cnt),
        .sampled_bit(sampled_bit),
        .frame_start(frame_start),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .two_stop   (two_stop),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_done (frame_done),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
`ifdef UART_FRAME_ERR_CNT_EN
        ,
        .err_clr    (err_clr),
        .par_err_cnt(par_err_cnt),
        .stp_err_cnt(stp_err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Monitor: every frame_done pops one expectation.
    always @(negedge CLK) begin
        if (RST) begin
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data_out",   32'(data_out),   32'(e.d));
                    check("data_valid", 32'(data_valid), 32'(e.v));
                    check("par_err",    32'(par_err),    32'(e.pe));
                    check("stp_err",    32'(stp_err),    32'(e.se));
                end
            end
            if (data_valid && !frame_done)
                check("valid_without_done", 32'(frame_done), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sampled_bit = b;
        for (int e = 0; e < 8; e++) begin
            edge_cnt = PW'(e);
            tick();
        end
    endtask

    task automatic start_frame(input logic pe, input logic pt, input logic ts);
        par_en      = pe;
        par_typ     = pt;
        two_stop    = ts;
        edge_cnt    = 6'd7;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d);
        logic [DW-1:0] v;
        v = d;
        for (int i = 0; i < DW; i++) send_bit(v[i]);
    endtask

    task automatic idle_ticks(input int n);
        edge_cnt    = '0;
        sampled_bit = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic ts, input logic pbit, input logic s1,
                             input logic s2, input logic exp_v, input logic exp_pe,
                             input logic exp_se, input logic clr_at_done);
        exp_t e;
        e.d = d; e.v = exp_v; e.pe = exp_pe; e.se = exp_se;
        exp_q.push_back(e);
        start_frame(pe, pt, ts);
        check("busy_after_start", 32'(busy), 32'd1);
        send_data(d);
        if (pe) send_bit(pbit);
        send_bit(s1);
        if (ts) begin
            check("no_done_after_first_stop", 32'(frame_done), 32'd0);
            check("busy_between_stops", 32'(busy), 32'd1);
            send_bit(s2);
        end
        check("done_latency", 32'(frame_done), 32'd1);
`ifdef UART_FRAME_ERR_CNT_EN
        err_clr = clr_at_done;
`else
        if (clr_at_done) $display("note: err_clr not present in this build");
`endif
        idle_ticks(1);
`ifdef UART_FRAME_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        check("idle_after_done", 32'(busy), 32'd0);
        idle_ticks(2);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_par_err",    32'(par_err),    32'd0);
        check("rst_stp_err",    32'(stp_err),    32'd0);
        RST = 1'b1;
        idle_ticks(3);

        // Frame 1: clean 0xA5, even parity bit 0
        run_frame(8'hA5, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        // Frame 2: parity error, then odd parity with bit 1 is clean
        run_frame(8'hA5, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        run_frame(8'hA5, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0);
        check("par_err_cleared_by_clean", 32'(par_err), 32'd0);
        // Frame 3: two stop bits, error on either stop is sticky
        run_frame(8'h3C, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        check("stp_err_holds", 32'(stp_err), 32'd1);
        run_frame(8'h3C, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
        run_frame(8'h3C, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);

        // Frame 4: abort after 4 data bits, then a clean 0x5A
        start_frame(0, 0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        run_frame(8'h5A, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);

        // frame_start on the final stop strobe wins over completion
        begin
            exp_t e;
            e.d = 8'hC3; e.v = 1'b1; e.pe = 1'b0; e.se = 1'b0;
            exp_q.push_back(e);
            start_frame(0, 0, 0);
            send_data(8'h11);
            sampled_bit = 1'b1;
            for (int k = 0; k < 7; k++) begin
                edge_cnt = PW'(k);
                tick();
            end
            start_frame(0, 0, 0);
            check("abort_on_final_stop_no_done", 32'(frame_done), 32'd0);
            check("abort_data_out_unchanged", 32'(data_out), 32'h5A);
            send_data(8'hC3);
            send_bit(1'b1);
            check("restart_done_latency", 32'(frame_done), 32'd1);
            idle_ticks(3);
        end

        // Reset mid-DATA: outputs clear immediately
        start_frame(1, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 RST = 1'b0;
        #1;
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_flags",    32'({data_valid, frame_done, par_err, stp_err}), 32'd0);
        idle_ticks(2);
        RST = 1'b1;
        idle_ticks(2);

        // Frame 5: par_en rises mid-DATA, latched 0 keeps stop at strobe 9
        begin
            exp_t e;
            e.d = 8'h96; e.v = 1'b1; e.pe = 1'b0; e.se = 1'b0;
            exp_q.push_back(e);
            start_frame(0, 0, 0);
            send_bit(0); send_bit(1); send_bit(1);
            par_en  = 1'b1;
            par_typ = 1'b1;
            send_bit(0); send_bit(1); send_bit(0); send_bit(0); send_bit(1);
            send_bit(1'b1);
            check("cfg_latched_done_at_9", 32'(frame_done), 32'd1);
            idle_ticks(3);
        end

`ifdef UART_FRAME_ERR_CNT_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("cnt_cleared_par", 32'(par_err_cnt), 32'd0);
        check("cnt_cleared_stp", 32'(stp_err_cnt), 32'd0);
        for (int i = 0; i < 5; i++)
            run_frame(8'hA5, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        check("par_cnt_saturates", 32'(par_err_cnt), 32'd3);
        check("stp_cnt_untouched", 32'(stp_err_cnt), 32'd0);
        run_frame(8'hA5, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1);
        check("clr_beats_inc_par", 32'(par_err_cnt), 32'd0);
        check("clr_beats_inc_stp", 32'(stp_err_cnt), 32'd0);
        run_frame(8'h0F, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        check("stp_cnt_inc", 32'(stp_err_cnt), 32'd1);
        check("par_cnt_no_inc", 32'(par_err_cnt), 32'd0);
`endif

        idle_ticks(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_check.md
Name: uart_frame_check

Overview:
- Parametrised UART RX frame checker for the receive path, downstream of the bit sampler and start-bit check.
- Once the start bit is confirmed, it:
  - accepts one sampled bit per bit period;
  - assembles DATA_WIDTH data bits, LSB first;
  - checks optional even/odd parity and one or two stop bits;
  - presents the data word with error flags.
- Generalises the single-stop-bit check to configurable width, parity and stop count, with abort and restart and optional error statistics.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
- PRESCALE_W, 6, width of PRESCALE and edge_cnt.
- ERR_CNT_W, 8, width of the saturating error counters (optional feature only).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- PRESCALE  in  PRESCALE_W  oversampling ratio, in CLK edges per bit.
- edge_cnt  in  PRESCALE_W  edge counter within the current bit period.
- sampled_bit  in  1  sampled (voted) line value.
- frame_start  in  1  one-cycle pulse: start bit confirmed at its last edge.
- par_en  in  1  parity bit present when 1.
- par_typ  in  1  parity type: 0 = even, 1 = odd.
- two_stop  in  1  two stop bits when 1, one stop bit when 0.
- data_out  out  DATA_WIDTH  assembled data word.
- data_valid  out  1  one-cycle pulse: frame complete with no error.
- frame_done  out  1  one-cycle pulse: frame complete, with or without error.
- par_err  out  1  parity error flag for the last frame.
- stp_err  out  1  stop error flag for the last frame.
- busy  out  1  high whenever the block is not in IDLE.

Behaviour:
- Bit strobe:
  - strobe = (edge_cnt == PRESCALE-1), compared modulo 2^PRESCALE_W.
  - PRESCALE < 2 is unsupported.
  - Strobes are only acted on outside IDLE.
- Reset: state IDLE; data_out = 0; all flags and pulses = 0; bit index = 0; internal running parity = 0.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - On frame_start: latch par_en, par_typ and two_stop; clear par_err, stp_err, bit index and internal running parity; go to DATA.
  - Config inputs are ignored outside this latch point.
- DATA:
  - Each strobe shifts sampled_bit into the data shift register MSB (LSB-first reception) and XORs it into the internal running parity.
  - After the DATA_WIDTH-th strobe: go to PARITY if the latched par_en is 1, else STOP.
- PARITY:
  - On strobe: par_err <= sampled_bit XOR (internal running parity XOR par_typ).
  - Go to STOP.
- STOP:
  - On each strobe: if sampled_bit == 0, set stp_err (sticky for the frame).
  - With two_stop latched, the first stop strobe stays in STOP; the final stop strobe completes the frame.
- Completion (cycle after the final stop strobe):
  - data_out is loaded from the shift register, so it holds only completed frames.
  - frame_done pulses for one cycle.
  - data_valid pulses for one cycle only if the final par_err = 0 and stp_err = 0, including an error set on the final stop strobe.
  - State returns to IDLE.
  - par_err and stp_err hold until the next frame_start.
  - Latency: frame_done = final stop strobe + 1 CLK.
- frame_start outside IDLE:
  - Aborts the current frame: no frame_done, no data_valid, data_out unchanged.
  - Restarts as in IDLE.
  - This also applies when frame_start coincides with the final stop strobe; frame_start wins.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: UART_FRAME_ERR_CNT_EN.
- When defined:
  - Adds input err_clr (1 bit) and outputs par_err_cnt and stp_err_cnt (ERR_CNT_W each).
  - On each frame_done, each counter whose flag is set increments by 1, saturating at all-ones.
  - err_clr clears both counters; it takes priority over a simultaneous increment.
  - Counters reset to 0.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state encoding (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - the parity type constants PAR_EVEN=1'b0 and PAR_ODD=1'b1.
- One sub-module, sat_err_counter (ERR_CNT_W; inc, clr, cnt), instantiated twice under the macro.

Test Plan:
- Frame 1 (clean): DATA_WIDTH=8, PRESCALE=8, par_en=1, par_typ=0, two_stop=0, data 0xA5 (bits 1,0,1,0,0,1,0,1), parity bit 0, stop 1 -> data_out=0xA5, data_valid and frame_done pulse 1 cycle after the stop strobe, par_err=0, stp_err=0.
- Frame 2 (parity error): same as frame 1 but parity bit 1 -> par_err=1, frame_done pulses, no data_valid. With par_typ=1 and parity bit 1 -> clean frame.
- Frame 3 (stop error): two_stop=1, par_en=0, data 0x3C, stops 1 then 0 -> stp_err=1, no data_valid. With stops 0 then 1 -> stp_err=1, since stp_err is sticky within the frame.
- Frame 4 (abort): frame_start pulsed after 4 data strobes, then a clean frame 0x5A is sent -> single frame_done, data_out=0x5A, no completion for the aborted frame. Also, RST low mid-DATA -> busy=0 and all outputs 0 immediately.
- Frame 5 (config latched): par_en toggled 0->1 mid-DATA with par_en=0 latched -> no PARITY state is entered and stop is sampled at strobe DATA_WIDTH+1.
- Counters (macro defined): ERR_CNT_W=2, 5 frames with parity error -> par_err_cnt saturates at 3. err_clr together with an error frame_done -> counters read 0.
